// File: rtl/mapper_pkg.sv
// Shared constants and helpers for the serial-load mapper register file.
// Defaults reproduce the MMC1 load register and its four targets.
package mapper_pkg;

  localparam int MMC1_DATA_W = 5;
  localparam int MMC1_NUM_REGS = 4;
  localparam logic [4:0] MMC1_CTRL_RESET = 5'h0C;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_SHIFT,
    WR_LAST,
    WR_RESET
  } wr_kind_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mapper_serial_shifter.sv
// Serial bit collector: consecutive-write filter, LSB-first shift
// register and bit counter; flags a completed word or a reset-bit write.
module mapper_serial_shifter
  import mapper_pkg::*;
#(
  parameter int DATA_W = MMC1_DATA_W,
  parameter bit CONSEC_FILTER = 1'b1,
  parameter int CNT_W = clog2(DATA_W)
) (
  input  logic              ck,
  input  logic              res,
  input  logic              wr_en,
  input  logic              wr_d7,
  input  logic              wr_d0,
  output logic              word_valid,
  output logic [DATA_W-1:0] word,
  output logic              ctrl_or,
  output logic [CNT_W-1:0]  shift_cnt
);

  logic [DATA_W-2:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prev_q;
  logic              accept;
  logic              full;
  wr_kind_e          kind;

  always_comb begin
    accept = wr_en & ~(CONSEC_FILTER & prev_q);
    full = (cnt_q == CNT_W'(DATA_W - 1));
    kind = WR_NONE;
    unique case (1'b1)
      ~accept:                  kind = WR_NONE;
      accept & wr_d7:           kind = WR_RESET;
      accept & ~wr_d7 & full:   kind = WR_LAST;
      accept & ~wr_d7 & ~full:  kind = WR_SHIFT;
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    cnt_d = cnt_q;
    unique case (kind)
      WR_SHIFT: begin
        // new bit enters at the top so bit 0 ends up in the LSB
        sr_d = sr_q >> 1;
        sr_d[DATA_W-2] = wr_d0;
        cnt_d = cnt_q + CNT_W'(1);
      end
      WR_LAST, WR_RESET: begin
        sr_d = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (res) begin
      sr_q <= '0;
      cnt_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      prev_q <= wr_en;
    end
  end

  assign word = {wr_d0, sr_q};
  assign word_valid = (kind == WR_LAST);
  assign ctrl_or = (kind == WR_RESET);
  assign shift_cnt = cnt_q;

endmodule

// File: rtl/mapper_serial_regfile.sv
// Serial-load register file: assembled words commit into the register
// addressed by the final write; reset-bit writes OR a mask into reg 0.
module mapper_serial_regfile
  import mapper_pkg::*;
#(
  parameter int DATA_W = MMC1_DATA_W,
  parameter int NUM_REGS = MMC1_NUM_REGS,
  parameter int ADDR_W = clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] CTRL_RESET = DATA_W'(MMC1_CTRL_RESET),
  parameter logic [DATA_W-1:0] CTRL_OR_MASK = DATA_W'(MMC1_CTRL_RESET),
  parameter bit CONSEC_FILTER = 1'b1
) (
  input  logic                       ck,
  input  logic                       res,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic                       wr_d7,
  input  logic                       wr_d0,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       commit,
  output logic [ADDR_W-1:0]          commit_idx,
  output logic [clog2(DATA_W)-1:0]   shift_cnt
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              commit_q, commit_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic              ctrl_or;
  logic              hit;

  mapper_serial_shifter #(
    .DATA_W        (DATA_W),
    .CONSEC_FILTER (CONSEC_FILTER)
  ) u_shifter (
    .ck         (ck),
    .res        (res),
    .wr_en      (wr_en),
    .wr_d7      (wr_d7),
    .wr_d0      (wr_d0),
    .word_valid (word_valid),
    .word       (word),
    .ctrl_or    (ctrl_or),
    .shift_cnt  (shift_cnt)
  );

  // out-of-range addresses match no register, so the word is dropped
  always_comb begin
    regs_d = regs_q;
    hit = 1'b0;
    if (ctrl_or) regs_d[0] = regs_q[0] | CTRL_OR_MASK;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (word_valid && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = word;
        hit = 1'b1;
      end
    end
    commit_d = hit;
    idx_d = hit ? wr_addr : idx_q;
  end

  always_ff @(posedge ck) begin
    if (res) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? CTRL_RESET : '0;
      end
      commit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      regs_q <= regs_d;
      commit_q <= commit_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign commit = commit_q;
  assign commit_idx = idx_q;

endmodule

// File: tb/tb_mapper_serial_regfile.sv
// Directed bench for mapper_serial_regfile: MMC1 default, unfiltered,
// and 8x8 instances share stimulus; commits are scored against queues.
module tb_mapper_serial_regfile;

  logic        ck;
  logic        res;
  logic        wr_en;
  logic        wr_d7;
  logic        wr_d0;
  logic [1:0]  addr_ab;
  logic [2:0]  addr_c;

  logic [19:0] regs_a, regs_b;
  logic        commit_a, commit_b, commit_c;
  logic [1:0]  idx_a, idx_b;
  logic [2:0]  cnt_a, cnt_b, cnt_c;
  logic [63:0] regs_c;
  logic [2:0]  idx_c;

  typedef struct {
    int          idx;
    logic [63:0] val;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks = 0;
  int errors = 0;
  bit chk_a, chk_b, chk_c;

  mapper_serial_regfile u_a (
    .ck(ck), .res(res), .wr_en(wr_en), .wr_addr(addr_ab),
    .wr_d7(wr_d7), .wr_d0(wr_d0), .regs(regs_a), .commit(commit_a),
    .commit_idx(idx_a), .shift_cnt(cnt_a)
  );

  mapper_serial_regfile #(.CONSEC_FILTER(1'b0)) u_b (
    .ck(ck), .res(res), .wr_en(wr_en), .wr_addr(addr_ab),
    .wr_d7(wr_d7), .wr_d0(wr_d0), .regs(regs_b), .commit(commit_b),
    .commit_idx(idx_b), .shift_cnt(cnt_b)
  );

  mapper_serial_regfile #(
    .DATA_W(8), .NUM_REGS(8),
    .CTRL_RESET(8'h0C), .CTRL_OR_MASK(8'h0C)
  ) u_c (
    .ck(ck), .res(res), .wr_en(wr_en), .wr_addr(addr_c),
    .wr_d7(wr_d7), .wr_d0(wr_d0), .regs(regs_c), .commit(commit_c),
    .commit_idx(idx_c), .shift_cnt(cnt_c)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic logic [19:0] p4(input logic [4:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop(input int d, output exp_t e);
    e.idx = -1;
    e.val = '1;
    case (d)
      0: if (q_a.size() > 0) e = q_a.pop_front();
      1: if (q_b.size() > 0) e = q_b.pop_front();
      default: if (q_c.size() > 0) e = q_c.pop_front();
    endcase
  endtask

  task automatic sb_check();
    exp_t e;
    if (chk_a && commit_a === 1'b1) begin
      pop(0, e);
      chk("sb_a_idx", 64'(idx_a), e.idx);
      chk("sb_a_val", 64'(regs_a[int'(idx_a)*5 +: 5]), e.val);
    end
    if (chk_b && commit_b === 1'b1) begin
      pop(1, e);
      chk("sb_b_idx", 64'(idx_b), e.idx);
      chk("sb_b_val", 64'(regs_b[int'(idx_b)*5 +: 5]), e.val);
    end
    if (chk_c && commit_c === 1'b1) begin
      pop(2, e);
      chk("sb_c_idx", 64'(idx_c), e.idx);
      chk("sb_c_val", 64'(regs_c[int'(idx_c)*8 +: 8]), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
    sb_check();
  endtask

  task automatic wr(input logic d7, input logic d0, input logic [2:0] a);
    wr_en = 1'b1;
    wr_d7 = d7;
    wr_d0 = d0;
    addr_ab = a[1:0];
    addr_c = a;
    cyc();
    wr_en = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    res = 1'b1;
    cyc();
    res = 1'b0;
  endtask

  task automatic expect_a(input int idx, input logic [4:0] v);
    exp_t e;
    e.idx = idx;
    e.val = 64'(v);
    q_a.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic [7:0] pat;
    res = 1'b1;
    wr_en = 1'b0;
    wr_d7 = 1'b0;
    wr_d0 = 1'b0;
    addr_ab = '0;
    addr_c = '0;
    chk_a = 1'b1;
    chk_b = 1'b0;
    chk_c = 1'b0;
    cyc();
    cyc();
    res = 1'b0;

    chk("rst_regs_a", 64'(regs_a), 64'(p4(5'h0C, 0, 0, 0)));
    chk("rst_commit_a", 64'(commit_a), 0);
    chk("rst_idx_a", 64'(idx_a), 0);
    chk("rst_cnt_a", 64'(cnt_a), 0);
    chk("rst_regs_c", regs_c, 64'h0C);

    // 1: basic 5-bit load, final address wins
    wr(0, 1, 0);
    wr(0, 0, 0);
    wr(0, 1, 0);
    chk("t1_cnt3", 64'(cnt_a), 3);
    wr(0, 1, 0);
    expect_a(1, 5'h0D);
    wr(0, 0, 1);
    chk("t1_regs", 64'(regs_a), 64'(p4(5'h0C, 5'h0D, 0, 0)));
    chk("t1_idx", 64'(idx_a), 1);
    chk("t1_commit_low", 64'(commit_a), 0);
    chk("t1_cnt0", 64'(cnt_a), 0);
    chk("t1_drain", 64'(q_a.size()), 0);

    // 2: reset bit mid-word ORs into reg 0 and aborts
    wr(0, 1, 0);
    wr(0, 0, 0);
    wr(0, 0, 0);
    wr(0, 0, 0);
    expect_a(0, 5'h11);
    wr(0, 1, 0);
    chk("t2_reg0", 64'(regs_a), 64'(p4(5'h11, 5'h0D, 0, 0)));
    wr(0, 0, 1);
    wr(0, 1, 1);
    wr(0, 0, 1);
    chk("t2_cnt3", 64'(cnt_a), 3);
    wr(1, 0, 1);
    chk("t2_cnt_clr", 64'(cnt_a), 0);
    chk("t2_or", 64'(regs_a), 64'(p4(5'h1D, 5'h0D, 0, 0)));
    for (int i = 0; i < 5; i++) begin
      if (i == 4) expect_a(2, 5'h1F);
      wr(0, 1, 2);
    end
    chk("t2_reg2", 64'(regs_a), 64'(p4(5'h1D, 5'h0D, 5'h1F, 0)));
    chk("t2_drain", 64'(q_a.size()), 0);

    // 3: back-to-back strobes, filtered vs unfiltered
    do_reset();
    chk_b = 1'b1;
    wr_en = 1'b1;
    wr_d7 = 1'b0;
    wr_d0 = 1'b1;
    addr_ab = 2'd3;
    cyc();
    cyc();
    cyc();
    wr_en = 1'b0;
    cyc();
    chk("t3_cnt_a", 64'(cnt_a), 1);
    chk("t3_cnt_b", 64'(cnt_b), 3);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        e.idx = 3;
        e.val = 64'h07;
        q_b.push_back(e);
      end
      if (i == 3) expect_a(3, 5'h01);
      wr(0, 0, 3);
    end
    chk("t3_regs_a", 64'(regs_a), 64'(p4(5'h0C, 0, 0, 5'h01)));
    chk("t3_regs_b", 64'(regs_b), 64'(p4(5'h0C, 0, 0, 5'h07)));
    chk("t3_cnt_b_cont", 64'(cnt_b), 2);
    chk("t3_drain_a", 64'(q_a.size()), 0);
    chk("t3_drain_b", 64'(q_b.size()), 0);
    chk_b = 1'b0;

    // 4: res on the fifth write discards the word
    do_reset();
    for (int i = 0; i < 4; i++) wr(0, 1, 1);
    chk("t4_cnt4", 64'(cnt_a), 4);
    wr_en = 1'b1;
    wr_d0 = 1'b1;
    res = 1'b1;
    cyc();
    res = 1'b0;
    wr_en = 1'b0;
    cyc();
    chk("t4_regs", 64'(regs_a), 64'(p4(5'h0C, 0, 0, 0)));
    chk("t4_cnt", 64'(cnt_a), 0);
    chk("t4_commit", 64'(commit_a), 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) expect_a(1, 5'h01);
      wr(0, (i == 0), 1);
    end
    chk("t4_bit0", 64'(regs_a), 64'(p4(5'h0C, 5'h01, 0, 0)));
    chk("t4_drain", 64'(q_a.size()), 0);

    // 5: only the address of the final write matters
    do_reset();
    wr(0, 0, 0);
    wr(0, 1, 0);
    wr(0, 0, 0);
    wr(0, 1, 0);
    expect_a(3, 5'h0A);
    wr(0, 0, 3);
    chk("t5_regs", 64'(regs_a), 64'(p4(5'h0C, 0, 0, 5'h0A)));
    chk("t5_idx", 64'(idx_a), 3);
    chk("t5_drain", 64'(q_a.size()), 0);

    // 7: reset bit right after another strobe is filtered
    do_reset();
    wr_en = 1'b1;
    wr_d7 = 1'b0;
    wr_d0 = 1'b1;
    addr_ab = 2'd0;
    cyc();
    wr_d7 = 1'b1;
    cyc();
    wr_en = 1'b0;
    wr_d7 = 1'b0;
    cyc();
    chk("t7_cnt_kept", 64'(cnt_a), 1);
    chk("t7_regs", 64'(regs_a), 64'(p4(5'h0C, 0, 0, 0)));

    // 6: 8-bit, 8-register instance
    chk_a = 1'b0;
    do_reset();
    chk_c = 1'b1;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        e.idx = 6;
        e.val = 64'hA5;
        q_c.push_back(e);
        chk("t6_cnt7", 64'(cnt_c), 7);
      end
      wr(0, pat[i], 3'd6);
    end
    chk("t6_cnt_wrap", 64'(cnt_c), 0);
    chk("t6_idx", 64'(idx_c), 6);
    chk("t6_regs", regs_c, (64'hA5 << 48) | 64'h0C);
    chk("t6_drain", 64'(q_c.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mapper_serial_regfile.md
Name: mapper_serial_regfile

Overview:
Parametrised serial-load register file for cartridge-mapper designs. It is the generalised successor of the fixed 5-bit, 4-register MMC1 load-register/shift logic. A CPU write strobe delivers one data bit, plus a "reset" bit, per accepted write. After DATA_W accepted bits, the assembled word commits into the register selected by the address of the final write. Width, register count, control reset/OR values and the consecutive-write filter are all parameters.

Parameters:
DATA_W, 5, bits per register and number of serial writes per commit (legal 2..16)
NUM_REGS, 4, number of target registers (legal 2..16)
ADDR_W, $clog2(NUM_REGS), width of the register select (derived; not overridden)
CTRL_RESET, 5'h0C (DATA_W wide), value of reg 0 after res
CTRL_OR_MASK, 5'h0C (DATA_W wide), bits OR-ed into reg 0 on a reset-bit write
CONSEC_FILTER, 1, 1 = ignore a write whose previous cycle also had wr_en high

Ports:
ck  in  1  clock; all state updates on its rising edge
res  in  1  reset, synchronous, active-high
wr_en  in  1  CPU write strobe; one cycle high per bus write
wr_addr  in  ADDR_W  register select (CPU A14:A13 in the MMC1 configuration)
wr_d7  in  1  serial reset bit
wr_d0  in  1  serial data bit
regs  out  NUM_REGS*DATA_W  register contents; reg i is at [i*DATA_W +: DATA_W]
commit  out  1  one-cycle pulse, the cycle after a commit edge
commit_idx  out  ADDR_W  index of the last committed register
shift_cnt  out  $clog2(DATA_W)  accepted bits currently held (0..DATA_W-1)

Behaviour:
- One clock domain. Everything is synchronous to ck. No latches, no asynchronous paths.
- Reset (res=1 at a ck edge) has highest priority and overrides wr_en that cycle.
  - reg 0 = CTRL_RESET; regs 1..NUM_REGS-1 = 0.
  - Shift register sr (DATA_W-1 bits) = 0; shift_cnt = 0.
  - commit = 0; commit_idx = 0; prev_wr = 0.
- Acceptance: accept = wr_en & ~(CONSEC_FILTER & prev_wr).
  - prev_wr <= wr_en every non-reset cycle, whether the write was accepted or not. A burst of N back-to-back strobes therefore accepts only the first.
- Accepted write with wr_d7=1 (reset bit):
  - sr = 0; shift_cnt = 0.
  - reg0 = reg0 | CTRL_OR_MASK.
  - No commit, even if shift_cnt == DATA_W-1.
- Accepted write with wr_d7=0 and shift_cnt < DATA_W-1:
  - sr = {wr_d0, sr[DATA_W-2:1]} (LSB-first assembly).
  - shift_cnt increments.
- Accepted write with wr_d7=0 and shift_cnt == DATA_W-1:
  - regs[wr_addr] = {wr_d0, sr}; only the final write's address matters.
  - sr = 0; shift_cnt = 0; commit_idx = wr_addr.
  - commit = 1 for exactly the next cycle.
- Latency: regs and commit both update at the edge that samples the final accepted write. They are visible one cycle after that write is presented.
- commit is deasserted on every cycle that is not a commit edge.
- Ignored writes (filtered) change nothing except prev_wr.
- Reset bit and filter interaction: a reset-bit write that arrives on the cycle after another strobe is also ignored (MMC1 RMW behaviour).
- wr_addr values >= NUM_REGS (non-power-of-2 counts only): the commit is dropped, sr and shift_cnt still clear, and commit is not pulsed.
- res asserted mid-sequence: partial bits are discarded and the next accepted write is bit 0.

Decomposition:
- Package mapper_pkg holds:
  - Default constants MMC1_DATA_W=5, MMC1_NUM_REGS=4, MMC1_CTRL_RESET=5'h0C.
  - A clog2 helper function.
- One sub-module, mapper_serial_shifter, owns sr, shift_cnt, the prev_wr filter and the accept/full/reset decode. It outputs word_valid, word, and ctrl_or.
- The top-level module owns the register array, the address decode, commit and commit_idx.

Test Plan:
1. Defaults; after res, writes of d0=1,0,1,1,0 (d7=0), each separated by an idle cycle, the last to wr_addr=1 -> reg1=5'h0D, commit high for one cycle, commit_idx=1, other regs unchanged, reg0=5'h0C.
2. Three accepted bits, then a write with d7=1 -> shift_cnt=0, reg0 |= 5'h0C, no commit. A following 5-bit sequence 1,1,1,1,1 to addr 2 -> reg2=5'h1F.
3. Filter: wr_en high for 3 consecutive cycles with d0=1, then 4 spaced writes of d0=0 to addr 3 -> reg3=5'h01. With CONSEC_FILTER=0 the same stimulus commits reg3=5'h07 after 5 strobes, and the remainder continues into the next word.
4. res asserted together with the fifth write -> no commit, regs return to reset values, shift_cnt=0.
5. Final write goes to a different address from the first four (first four to addr 0, fifth to addr 3) -> only reg3 changes.
6. DATA_W=8, NUM_REGS=8: eight spaced writes of bits of 8'hA5, LSB first, to addr 6 -> reg6=8'hA5, commit_idx=6, shift_cnt wraps from 7 to 0.
